// File: rtl/axi_llc_refill_ar_issue.sv
// rtl/axi_llc_refill_ar_issue.sv - issues one AXI AR burst per LLC refill descriptor and forwards descriptors in order
module axi_llc_refill_ar_issue #(
   parameter int unsigned AddrWidth      = 32,
   parameter int unsigned IdWidth        = 4,
   parameter int unsigned AxiId          = 0,
   parameter int unsigned DataWidth      = 64,
   parameter int unsigned BlockSize      = 8,
   parameter int unsigned WayWidth       = 8,
   parameter int unsigned TagWidth       = 16,
   parameter int unsigned MaxOutstanding = 4,
   localparam int unsigned CntWidth      = $clog2(MaxOutstanding + 1)
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 desc_valid_i,
   output logic                 desc_ready_o,
   input  logic [AddrWidth-1:0] desc_addr_i,
   input  logic [WayWidth-1:0]  desc_way_i,
   input  logic                 desc_refill_i,
   input  logic [TagWidth-1:0]  desc_tag_i,
   output logic                 desc_valid_o,
   input  logic                 desc_ready_i,
   output logic [AddrWidth-1:0] desc_addr_o,
   output logic [WayWidth-1:0]  desc_way_o,
   output logic                 desc_refill_o,
   output logic [TagWidth-1:0]  desc_tag_o,
   output logic                 ar_valid_o,
   input  logic                 ar_ready_i,
   output logic [AddrWidth-1:0] ar_addr_o,
   output logic [IdWidth-1:0]   ar_id_o,
   output logic [7:0]           ar_len_o,
   output logic [2:0]           ar_size_o,
   output logic [1:0]           ar_burst_o,
   input  logic                 refill_done_i,
   output logic [CntWidth-1:0]  outstanding_o
);

   localparam int unsigned SizeLog = $clog2(DataWidth / 8);
   localparam int unsigned LineOff = $clog2(BlockSize) + SizeLog;
   localparam logic [CntWidth-1:0] MaxCnt = CntWidth'(MaxOutstanding);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE_AR,
      SEND_DESC
   } state_e;

   state_e                state_q, state_d;
   logic [AddrWidth-1:0]  addr_q;
   logic [WayWidth-1:0]   way_q;
   logic                  refill_q;
   logic [TagWidth-1:0]   tag_q;
   logic [CntWidth-1:0]   cnt_q, cnt_d;
   logic                  load;
   logic                  ar_fire;
   logic                  done_ok;
   logic                  credit_ok;

   assign credit_ok = (cnt_q < MaxCnt);

   always_comb begin
      state_d      = state_q;
      desc_ready_o = 1'b0;
      desc_valid_o = 1'b0;
      ar_valid_o   = 1'b0;
      load         = 1'b0;
      case (state_q)
         IDLE: begin
            desc_ready_o = 1'b1;
            if (desc_valid_i) begin
               load    = 1'b1;
               state_d = desc_refill_i ? ISSUE_AR : SEND_DESC;
            end
         end
         ISSUE_AR: begin
            ar_valid_o = credit_ok;
            if (credit_ok && ar_ready_i) begin
               state_d = SEND_DESC;
            end
         end
         SEND_DESC: begin
            desc_valid_o = 1'b1;
            if (desc_ready_i) begin
               desc_ready_o = 1'b1;
               if (desc_valid_i) begin
                  load    = 1'b1;
                  state_d = desc_refill_i ? ISSUE_AR : SEND_DESC;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // A completion arriving with nothing in flight is dropped so the count never wraps.
   assign ar_fire = ar_valid_o && ar_ready_i;
   assign done_ok = refill_done_i && (cnt_q != '0);

   always_comb begin
      cnt_d = cnt_q;
      case ({ar_fire, done_ok})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         way_q    <= '0;
         refill_q <= 1'b0;
         tag_q    <= '0;
         cnt_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (load) begin
            addr_q   <= desc_addr_i;
            way_q    <= desc_way_i;
            refill_q <= desc_refill_i;
            tag_q    <= desc_tag_i;
         end
      end
   end

   assign desc_addr_o   = addr_q;
   assign desc_way_o    = way_q;
   assign desc_refill_o = refill_q;
   assign desc_tag_o    = tag_q;
   assign outstanding_o = cnt_q;

   assign ar_addr_o  = {addr_q[AddrWidth-1:LineOff], {LineOff{1'b0}}};
   assign ar_id_o    = IdWidth'(AxiId);
   assign ar_len_o   = 8'(BlockSize - 1);
   assign ar_size_o  = 3'(SizeLog);
   assign ar_burst_o = 2'b01;

endmodule

// File: tb/tb_axi_llc_refill_ar_issue.sv
// tb/tb_axi_llc_refill_ar_issue.sv - directed vector bench for axi_llc_refill_ar_issue
module tb_axi_llc_refill_ar_issue;

   logic        clk;
   logic        rst;
   logic        dv_i, dr_o, refill_i, dv_o, dr_i, refill_o;
   logic [31:0] addr_i, addr_o, ar_addr;
   logic [7:0]  way_i, way_o, ar_len;
   logic [15:0] tag_i, tag_o;
   logic        ar_valid, ar_ready, done;
   logic [3:0]  ar_id;
   logic [2:0]  ar_size, outst;
   logic [1:0]  ar_burst;

   int checks = 0;
   int errors = 0;

   axi_llc_refill_ar_issue dut (
      .clk_i(clk), .rst_i(rst),
      .desc_valid_i(dv_i), .desc_ready_o(dr_o),
      .desc_addr_i(addr_i), .desc_way_i(way_i), .desc_refill_i(refill_i), .desc_tag_i(tag_i),
      .desc_valid_o(dv_o), .desc_ready_i(dr_i),
      .desc_addr_o(addr_o), .desc_way_o(way_o), .desc_refill_o(refill_o), .desc_tag_o(tag_o),
      .ar_valid_o(ar_valid), .ar_ready_i(ar_ready), .ar_addr_o(ar_addr), .ar_id_o(ar_id),
      .ar_len_o(ar_len), .ar_size_o(ar_size), .ar_burst_o(ar_burst),
      .refill_done_i(done), .outstanding_o(outst)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        dv;
      logic [31:0] addr;
      logic        refill;
      logic [15:0] tag;
      logic        dr;
      logic        arr;
      logic        done;
      logic        e_dro;
      logic        e_dvo;
      logic        e_arv;
      logic [31:0] e_araddr;
      logic [31:0] e_daddr;
      logic [15:0] e_tag;
      logic [2:0]  e_out;
   } vec_t;

   vec_t vecs[12];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Inputs change on the falling edge; outputs are sampled 1ns later, well before the next rising edge.
   task automatic drive(input logic r, input logic v, input logic [31:0] a, input logic rf,
                        input logic [15:0] t, input logic d_rdy, input logic a_rdy, input logic dn);
      @(negedge clk);
      rst = r; dv_i = v; addr_i = a; refill_i = rf; tag_i = t; way_i = t[7:0];
      dr_i = d_rdy; ar_ready = a_rdy; done = dn;
      #1;
   endtask

   task automatic refill_cycle(input logic [31:0] a, input logic [15:0] t);
      drive(0, 1, a, 1, t, 1, 1, 0);
      drive(0, 0, 0, 0, 0, 1, 1, 0);
      chk("refill_arv", {31'b0, ar_valid}, 32'd1);
      drive(0, 0, 0, 0, 0, 1, 1, 0);
      chk("refill_dvo", {31'b0, dv_o}, 32'd1);
   endtask

   initial begin
      rst = 1; dv_i = 0; addr_i = 0; refill_i = 0; tag_i = 0; way_i = 0;
      dr_i = 0; ar_ready = 0; done = 0;
      //          dv addr          rf tag       dr arr dn  dro dvo arv araddr        daddr         tag       out
      vecs[0]  = '{0, 32'h0,        0, 16'h0,    0, 0, 0,  1,  0,  0, 32'h0,        32'h0,        16'h0,    3'd0};
      vecs[1]  = '{1, 32'h0000_1234,1, 16'h00A1, 1, 1, 0,  1,  0,  0, 32'h0,        32'h0,        16'h0,    3'd0};
      vecs[2]  = '{0, 32'h0,        0, 16'h0,    1, 1, 0,  0,  0,  1, 32'h0000_1200,32'h0000_1234,16'h00A1, 3'd0};
      vecs[3]  = '{1, 32'h0000_0100,0, 16'h00B0, 1, 0, 0,  1,  1,  0, 32'h0000_1200,32'h0000_1234,16'h00A1, 3'd1};
      vecs[4]  = '{1, 32'h0000_0204,0, 16'h00B1, 1, 0, 0,  1,  1,  0, 32'h0000_0100,32'h0000_0100,16'h00B0, 3'd1};
      vecs[5]  = '{1, 32'h0000_0308,0, 16'h00B2, 1, 0, 0,  1,  1,  0, 32'h0000_0200,32'h0000_0204,16'h00B1, 3'd1};
      vecs[6]  = '{1, 32'h0000_040C,0, 16'h00B3, 1, 0, 0,  1,  1,  0, 32'h0000_0300,32'h0000_0308,16'h00B2, 3'd1};
      vecs[7]  = '{0, 32'h0,        0, 16'h0,    1, 0, 0,  1,  1,  0, 32'h0000_0400,32'h0000_040C,16'h00B3, 3'd1};
      vecs[8]  = '{0, 32'h0,        0, 16'h0,    1, 0, 0,  1,  0,  0, 32'h0000_0400,32'h0000_040C,16'h00B3, 3'd1};
      vecs[9]  = '{0, 32'h0,        0, 16'h0,    1, 0, 1,  1,  0,  0, 32'h0000_0400,32'h0000_040C,16'h00B3, 3'd1};
      vecs[10] = '{0, 32'h0,        0, 16'h0,    1, 0, 1,  1,  0,  0, 32'h0000_0400,32'h0000_040C,16'h00B3, 3'd0};
      vecs[11] = '{0, 32'h0,        0, 16'h0,    1, 0, 0,  1,  0,  0, 32'h0000_0400,32'h0000_040C,16'h00B3, 3'd0};

      repeat (2) @(posedge clk);

      for (int i = 0; i < 12; i++) begin
         drive(0, vecs[i].dv, vecs[i].addr, vecs[i].refill, vecs[i].tag,
               vecs[i].dr, vecs[i].arr, vecs[i].done);
         chk($sformatf("v%0d desc_ready_o", i), {31'b0, dr_o}, {31'b0, vecs[i].e_dro});
         chk($sformatf("v%0d desc_valid_o", i), {31'b0, dv_o}, {31'b0, vecs[i].e_dvo});
         chk($sformatf("v%0d ar_valid_o", i), {31'b0, ar_valid}, {31'b0, vecs[i].e_arv});
         chk($sformatf("v%0d ar_addr_o", i), ar_addr, vecs[i].e_araddr);
         chk($sformatf("v%0d desc_addr_o", i), addr_o, vecs[i].e_daddr);
         chk($sformatf("v%0d desc_tag_o", i), {16'b0, tag_o}, {16'b0, vecs[i].e_tag});
         chk($sformatf("v%0d desc_way_o", i), {24'b0, way_o}, {24'b0, vecs[i].e_tag[7:0]});
         chk($sformatf("v%0d outstanding_o", i), {29'b0, outst}, {29'b0, vecs[i].e_out});
      end
      chk("ar_len", {24'b0, ar_len}, 32'd7);
      chk("ar_size", {29'b0, ar_size}, 32'd3);
      chk("ar_burst", {30'b0, ar_burst}, 32'd1);
      chk("ar_id", {28'b0, ar_id}, 32'd0);

      // Fill all four credits, then a fifth refill must stall until a line completes.
      for (int k = 0; k < 4; k++) refill_cycle(32'h1000 + k * 32'h40, 16'h0C00 + 16'(k));
      drive(0, 0, 0, 0, 0, 1, 1, 0);
      chk("limit_out4", {29'b0, outst}, 32'd4);
      drive(0, 1, 32'h0000_2000, 1, 16'h0D00, 1, 1, 0);
      drive(0, 0, 0, 0, 0, 1, 1, 0);
      chk("limit_arv_blocked0", {31'b0, ar_valid}, 32'd0);
      drive(0, 0, 0, 0, 0, 1, 1, 0);
      chk("limit_arv_blocked1", {31'b0, ar_valid}, 32'd0);
      chk("limit_dvo_blocked", {31'b0, dv_o}, 32'd0);
      drive(0, 0, 0, 0, 0, 1, 1, 1);
      chk("limit_arv_on_done", {31'b0, ar_valid}, 32'd0);
      drive(0, 0, 0, 0, 0, 1, 1, 0);
      chk("limit_arv_released", {31'b0, ar_valid}, 32'd1);
      chk("limit_out3", {29'b0, outst}, 32'd3);
      drive(0, 0, 0, 0, 0, 1, 1, 0);
      chk("limit_out_back4", {29'b0, outst}, 32'd4);
      chk("limit_dvo", {31'b0, dv_o}, 32'd1);

      // Two completions bring the count to 2, then AR handshake and completion coincide.
      drive(0, 0, 0, 0, 0, 1, 1, 1);
      drive(0, 0, 0, 0, 0, 1, 1, 1);
      drive(0, 1, 32'h0000_3000, 1, 16'h0E00, 1, 1, 0);
      chk("simul_out2_pre", {29'b0, outst}, 32'd2);
      drive(0, 0, 0, 0, 0, 1, 1, 1);
      chk("simul_arv", {31'b0, ar_valid}, 32'd1);
      drive(0, 0, 0, 0, 0, 1, 1, 0);
      chk("simul_out2_post", {29'b0, outst}, 32'd2);

      // AR backpressure followed by descriptor backpressure.
      drive(0, 1, 32'hABCD_EF7F, 1, 16'h0F55, 1, 0, 0);
      for (int k = 0; k < 5; k++) begin
         drive(0, 0, 0, 0, 0, 1, 0, 0);
         chk($sformatf("arbp%0d ar_valid", k), {31'b0, ar_valid}, 32'd1);
         chk($sformatf("arbp%0d ar_addr", k), ar_addr, 32'hABCD_EF40);
         chk($sformatf("arbp%0d dvo", k), {31'b0, dv_o}, 32'd0);
         chk($sformatf("arbp%0d dro", k), {31'b0, dr_o}, 32'd0);
      end
      drive(0, 0, 0, 0, 0, 1, 1, 0);
      chk("arbp_hs", {31'b0, ar_valid}, 32'd1);
      for (int k = 0; k < 3; k++) begin
         drive(0, 1, 32'h5555_5555, 0, 16'h1111, 0, 0, 0);
         chk($sformatf("dbp%0d dvo", k), {31'b0, dv_o}, 32'd1);
         chk($sformatf("dbp%0d dro", k), {31'b0, dr_o}, 32'd0);
         chk($sformatf("dbp%0d addr", k), addr_o, 32'hABCD_EF7F);
         chk($sformatf("dbp%0d tag", k), {16'b0, tag_o}, 32'h0F55);
      end
      drive(0, 0, 0, 0, 0, 1, 0, 0);
      chk("dbp_release_dro", {31'b0, dr_o}, 32'd1);
      chk("dbp_out3", {29'b0, outst}, 32'd3);

      // Reset while an AR is pending with three bursts in flight.
      drive(0, 1, 32'h0000_4000, 1, 16'h0777, 1, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      chk("rst_pre_arv", {31'b0, ar_valid}, 32'd1);
      chk("rst_pre_out", {29'b0, outst}, 32'd3);
      drive(1, 0, 0, 0, 0, 0, 1, 0);
      drive(0, 0, 0, 0, 0, 0, 1, 0);
      chk("rst_arv", {31'b0, ar_valid}, 32'd0);
      chk("rst_dvo", {31'b0, dv_o}, 32'd0);
      chk("rst_out", {29'b0, outst}, 32'd0);
      chk("rst_dro", {31'b0, dr_o}, 32'd1);
      chk("rst_addr", addr_o, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/axi_llc_refill_ar_issue.md
Name: axi_llc_refill_ar_issue

Overview:
- Upstream neighbour of the refill R-beat stage.
- Accepts LLC descriptors from the miss path and issues one AXI AR burst per refill descriptor on the master port, covering one full cache line.
- Forwards every descriptor, refill or not, in order to the downstream R stage. A refill descriptor is forwarded only after its AR handshake.
- Bounds the number of in-flight refill bursts with an outstanding counter, which the R stage decrements on each completed line.

Parameters:
- AddrWidth, 32, AXI address width.
- IdWidth, 4, AXI ID width.
- AxiId, 0, fixed ID driven on every AR.
- DataWidth, 64, AXI data width in bits (power of 2, ≥8).
- BlockSize, 8, beats per cache line (power of 2, ≤256).
- WayWidth, 8, width of the one-hot way indicator.
- TagWidth, 16, width of the opaque descriptor payload, passed through untouched.
- MaxOutstanding, 4, maximum AR bursts issued whose line is not yet completed (≥1).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- desc_valid_i  in  1  input descriptor valid.
- desc_ready_o  out  1  ready for input descriptor.
- desc_addr_i  in  AddrWidth  request address.
- desc_way_i  in  WayWidth  target way.
- desc_refill_i  in  1  descriptor needs a line refill.
- desc_tag_i  in  TagWidth  opaque payload.
- desc_valid_o  out  1  output descriptor valid (to R stage).
- desc_ready_i  in  1  R stage ready.
- desc_addr_o / desc_way_o / desc_refill_o / desc_tag_o  out  as inputs  registered copy of the accepted descriptor.
- ar_valid_o  out  1  AXI AR valid.
- ar_ready_i  in  1  AXI AR ready.
- ar_addr_o  out  AddrWidth  line-aligned address.
- ar_id_o  out  IdWidth  equals AxiId.
- ar_len_o  out  8  BlockSize-1.
- ar_size_o  out  3  log2(DataWidth/8).
- ar_burst_o  out  2  2'b01 (INCR).
- refill_done_i  in  1  single-cycle pulse from R stage on the last R beat of a line.
- outstanding_o  out  $clog2(MaxOutstanding+1)  current in-flight refill count.

Behaviour:
- All state changes on the rising edge of clk_i.
- rst_i is synchronous and active-high. When sampled high, it forces the following regardless of any other input:
  - state = IDLE
  - descriptor register = 0
  - counter = 0
  - desc_ready_o = 1 (combinational in IDLE)
  - desc_valid_o = 0
  - ar_valid_o = 0
- Mid-operation reset drops any held descriptor and pending AR without handshake.
- Line offset LO = log2(BlockSize) + log2(DataWidth/8).
- AR field values:
  - ar_addr_o = {desc_addr_q[AddrWidth-1:LO], LO'b0}.
  - ar_len_o, ar_size_o, ar_burst_o and ar_id_o are constants.
- Three-state FSM:
  - IDLE
    - desc_ready_o = 1.
    - On desc_valid_i: capture the descriptor.
    - Next state is ISSUE_AR if desc_refill_i is set, otherwise SEND_DESC.
  - ISSUE_AR
    - ar_valid_o = (outstanding < MaxOutstanding).
    - On ar_valid_o && ar_ready_i: go to SEND_DESC.
    - Once asserted, ar_valid_o cannot drop before the handshake: the counter only decreases while in this state.
  - SEND_DESC
    - desc_valid_o = 1, outputs stable until accepted.
    - On desc_ready_i: desc_ready_o = 1 in the same cycle.
    - If desc_valid_i is also high in that cycle, load the new descriptor and go to ISSUE_AR or SEND_DESC by its refill flag. Otherwise go to IDLE.
- desc_ready_o is 0 in ISSUE_AR, and 0 in SEND_DESC while desc_ready_i is low.
- Minimum latency:
  - Refill descriptor in (cycle 0) -> AR valid at cycle 1 -> descriptor out at cycle 2 at the earliest.
  - Non-refill descriptor: out at cycle 1.
- Throughput: one non-refill descriptor per cycle when desc_ready_i is held high.
- Outstanding counter:
  - +1 on AR handshake; -1 on refill_done_i.
  - Both in the same cycle: unchanged.
  - refill_done_i when the counter is 0 is ignored; the counter saturates at 0 and never underflows.
  - The counter never exceeds MaxOutstanding.
- Descriptor fields on the outputs always reflect the registered descriptor, including in IDLE (last value; 0 after reset).

Test Plan:
- Refill, defaults: desc addr 0x0000_1234, refill=1, ar_ready=1, desc_ready=1.
  - ar_valid at cycle 1 with addr 0x0000_1200, len 7, size 3, burst 1, id 0.
  - desc_valid at cycle 2.
  - outstanding goes 0->1.
- Non-refill stream: 4 back-to-back descriptors, refill=0, desc_ready=1.
  - Each appears on desc_*_o one cycle after acceptance, one per cycle, in order.
  - ar_valid stays 0.
- Outstanding limit (MaxOutstanding=4):
  - Issue 4 refills with no refill_done. The 5th refill holds ar_valid=0 in ISSUE_AR.
  - Pulse refill_done: ar_valid=1 next cycle, outstanding returns to 4 after the handshake.
- Simultaneous events:
  - AR handshake and refill_done in the same cycle at outstanding=2 -> remains 2.
  - refill_done at 0 -> stays 0.
- Backpressure:
  - ar_ready low for 5 cycles: ar_valid and ar_addr stay stable throughout; no desc_valid until the handshake.
  - desc_ready low for 3 cycles: desc_*_o stay stable and desc_ready_o=0.
- Reset mid-operation: assert rst_i in ISSUE_AR with outstanding=3.
  - Next cycle: ar_valid=0, desc_valid=0, outstanding=0, desc_ready_o=1.
